// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a count-prefixed, XOR-checksummed byte
// stream into 32-bit little-endian words and releases the cores on a clean load.
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             we,
    output logic [31:0]      wa,
    output logic [31:0]      wd,
    output logic             core_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] words_loaded_reg;
    logic [1:0]       byte_idx_reg;
    logic [7:0]       xor_reg;
    logic [31:0]      asm_reg;
    logic [31:0]      asm_next;
    logic             we_reg;
    logic [31:0]      wa_reg;
    logic [31:0]      wd_reg;

    logic accept;
    logic bad_count;
    logic last_word;
    logic session_start;

    assign in_ready      = (state_reg == COUNT) || (state_reg == DATA) || (state_reg == CHECK);
    assign accept        = in_valid & in_ready;
    assign bad_count     = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_B);
    assign last_word     = (words_loaded_reg + CNT_W'(1)) == n_reg;
    assign session_start = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));

    // Each lane takes the incoming byte only when the byte index selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_next[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? in_data : asm_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) state_next = COUNT;
            end
            COUNT: begin
                if (accept) state_next = bad_count ? ERROR : DATA;
            end
            DATA: begin
                if (accept && (byte_idx_reg == 2'd3) && last_word) state_next = CHECK;
            end
            CHECK: begin
                if (accept) state_next = (in_data == xor_reg) ? DONE : ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            n_reg            <= '0;
            words_loaded_reg <= '0;
            byte_idx_reg     <= '0;
            xor_reg          <= '0;
            asm_reg          <= '0;
            we_reg           <= 1'b0;
            wa_reg           <= '0;
            wd_reg           <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= 1'b0;
            if (session_start) begin
                words_loaded_reg <= '0;
                byte_idx_reg     <= '0;
                xor_reg          <= '0;
                asm_reg          <= '0;
            end
            if ((state_reg == COUNT) && accept && !bad_count) begin
                n_reg <= in_data[CNT_W-1:0];
            end
            if ((state_reg == DATA) && accept) begin
                asm_reg      <= asm_next;
                xor_reg      <= xor_reg ^ in_data;
                byte_idx_reg <= byte_idx_reg + 2'd1;
                // Word complete: issue the write using the pre-increment count.
                if (byte_idx_reg == 2'd3) begin
                    we_reg           <= 1'b1;
                    wa_reg           <= 32'({words_loaded_reg, 2'b00});
                    wd_reg           <= asm_next;
                    words_loaded_reg <= words_loaded_reg + CNT_W'(1);
                end
            end
        end
    end

    assign we           = we_reg;
    assign wa           = wa_reg;
    assign wd           = wd_reg;
    assign core_hold    = (state_reg != DONE);
    assign done         = (state_reg == DONE);
    assign err          = (state_reg == ERROR);
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected writes and outcome come from a
// stream-level model of the load protocol.
module tb_imem_loader;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             we;
    logic [31:0]      wa;
    logic [31:0]      wd;
    logic             core_hold;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] obs_wa [$];
    logic [31:0] obs_wd [$];

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .core_hold(core_hold),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_wa.push_back(wa);
            obs_wd.push_back(wd);
            $display("write wa=%08h wd=%08h words_loaded=%0d", wa, wd, words_loaded);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one byte after `stall` idle cycles and holds it until accepted.
    task automatic send_byte(input logic [7:0] b, input int stall);
        logic acc;
        int   guard;
        repeat (stall) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 40) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) check("hold_in_session", core_hold, 1'b1);
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 1'b0, 1'b1);
    endtask

    // Runs one session and compares the DUT against the protocol-level model.
    task automatic run_session(input string tag, input logic [7:0] bytes [$],
                               input int stall_lo, input int stall_hi);
        int          n;
        logic        count_ok;
        logic [7:0]  x;
        logic [31:0] exp_wd [$];
        logic        exp_done;
        int          n_send;
        n        = int'(bytes[0]);
        count_ok = (n >= 1) && (n <= DEPTH);
        x        = 8'h00;
        exp_wd.delete();
        if (count_ok) begin
            for (int w = 0; w < n; w++) begin
                exp_wd.push_back({bytes[4*w+4], bytes[4*w+3], bytes[4*w+2], bytes[4*w+1]});
                for (int k = 1; k <= 4; k++) x = x ^ bytes[4*w+k];
            end
            exp_done = (bytes[4*n+1] == x);
            n_send   = 4*n + 2;
        end else begin
            exp_done = 1'b0;
            n_send   = 1;
        end

        obs_wa.delete();
        obs_wd.delete();
        in_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < n_send; i++) begin
            send_byte(bytes[i], (i == 0) ? 0 : int'($urandom_range(stall_hi, stall_lo)));
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check({tag, "_nwrites"}, obs_wa.size(), exp_wd.size());
        for (int i = 0; i < exp_wd.size() && i < obs_wa.size(); i++) begin
            check({tag, "_wa"}, obs_wa[i], 32'(i * 4));
            check({tag, "_wd"}, obs_wd[i], exp_wd[i]);
        end
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, err, !exp_done);
        check({tag, "_hold"}, core_hold, !exp_done);
        check({tag, "_ready"}, in_ready, 1'b0);
        check({tag, "_words"}, words_loaded, count_ok ? n : 0);
        $display("session %s n=%0d writes=%0d done=%0b err=%0b", tag, n, obs_wa.size(), done, err);
    endtask

    initial begin
        logic [7:0] clean [$];
        logic [7:0] s [$];
        logic [7:0] x;
        int         n;

        clean = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h20};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_wa", wa, 32'h0);
        check("rst_wd", wd, 32'h0);
        check("rst_hold", core_hold, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words", words_loaded, 0);

        // Bytes offered before any start must be ignored.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        obs_wa.delete();
        repeat (4) begin
            @(negedge clk);
            check("idle_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("idle_nowrite", obs_wa.size(), 0);

        run_session("clean", clean, 0, 0);

        s = clean;
        s[9] = 8'h21;
        run_session("badsum", s, 0, 0);

        s = '{8'h00};
        run_session("cnt0", s, 0, 0);
        s = '{8'h11};
        run_session("cnt17", s, 0, 0);

        run_session("gapped", clean, 3, 3);

        // Abort mid-load with reset, then verify a fresh load still works.
        in_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(clean[i], 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_ready", in_ready, 1'b0);
        check("mid_we", we, 1'b0);
        check("mid_wa", wa, 32'h0);
        check("mid_wd", wd, 32'h0);
        check("mid_hold", core_hold, 1'b1);
        check("mid_done", done, 1'b0);
        check("mid_err", err, 1'b0);
        check("mid_words", words_loaded, 0);
        run_session("after_rst", clean, 0, 0);

        s = '{};
        s.push_back(8'd16);
        for (int w = 0; w < 16; w++) begin
            s.push_back(8'(w));
            s.push_back(8'h00);
            s.push_back(8'h00);
            s.push_back(8'h00);
        end
        s.push_back(8'h00);
        run_session("full", s, 0, 0);

        for (int r = 0; r < 8; r++) begin
            s = '{};
            n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(255, 17)) : int'($urandom_range(DEPTH, 1));
            s.push_back(8'(n));
            x = 8'h00;
            if (n <= DEPTH) begin
                for (int k = 0; k < 4 * n; k++) begin
                    s.push_back(8'($urandom));
                    x = x ^ s[s.size() - 1];
                end
                if ($urandom_range(2, 0) == 0) x = x ^ 8'(($urandom_range(255, 1)));
                s.push_back(x);
            end
            run_session($sformatf("rand%0d", r), s, 0, 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
